// File: rtl/otter_io_pkg.sv
// ============================================================================
// otter_io_pkg : register offsets, STATUS bit positions and UART TX state type
// Revision     : 1.0
// ============================================================================
`default_nettype none

package otter_io_pkg;

  localparam logic [31:0] TXDATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS   = 32'd4;

  localparam int          STAT_BUSY    = 0;
  localparam int          STAT_FULL    = 1;
  localparam int          STAT_EMPTY   = 2;
  localparam int          STAT_OVF     = 3;
  localparam int          STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/iobus_uart_tx_if.sv
// ============================================================================
// iobus_uart_tx_if : CPU IOBUS request/response signals for one IO responder
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface iobus_uart_tx_if;

  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] rd_data;
  logic        sel;

  modport master (
    output iobus_addr,
    output iobus_out,
    output iobus_wr,
    input  rd_data,
    input  sel
  );

  modport slave (
    input  iobus_addr,
    input  iobus_out,
    input  iobus_wr,
    output rd_data,
    output sel
  );

endinterface

`default_nettype wire

// File: rtl/io_sync_fifo.sv
// ============================================================================
// io_sync_fifo : single-clock show-ahead FIFO; a push into a full FIFO is
//                accepted only when a pop happens on the same edge
// Revision     : 1.0
// ============================================================================
`default_nettype none

module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iobus_uart_tx.sv
// ============================================================================
// iobus_uart_tx : IOBUS-mapped UART transmitter (TXDATA/STATUS, 8N1, TX FIFO)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module iobus_uart_tx
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  iobus_uart_tx_if.slave     bus,
  output logic               tx
);

  localparam int          BW          = $clog2(CLKS_PER_BIT);
  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TX_ADDR     = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0] ST_ADDR     = BASE_ADDR + STATUS_OFS;

  logic           w_hit_tx;
  logic           w_hit_st;
  logic           w_push;
  logic           w_pop;
  logic           w_clr_ovf;
  logic           w_full;
  logic           w_empty;
  logic [7:0]     w_dout;
  logic [CW-1:0]  w_count;
  logic [31:0]    w_status;
  logic           w_unused;
  logic           r_ovf;

  uart_tx_state_t r_state, w_state_nxt;
  logic [BW-1:0]  r_baud, w_baud_nxt;
  logic [2:0]     r_bit, w_bit_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic           r_tx, w_tx_nxt;

  // Byte lanes are ignored: only the word address takes part in the decode.
  assign w_hit_tx  = (bus.iobus_addr[31:2] == TX_ADDR[31:2]);
  assign w_hit_st  = (bus.iobus_addr[31:2] == ST_ADDR[31:2]);
  assign w_push    = bus.iobus_wr && w_hit_tx;
  assign w_clr_ovf = bus.iobus_wr && w_hit_st && bus.iobus_out[STAT_OVF];
  assign w_unused  = ^{bus.iobus_addr[1:0], bus.iobus_out[31:8]};

  always_comb begin
    w_status                        = '0;
    w_status[STAT_BUSY]             = (r_state != IDLE);
    w_status[STAT_FULL]             = w_full;
    w_status[STAT_EMPTY]            = w_empty;
    w_status[STAT_OVF]              = r_ovf;
    w_status[STAT_CNT_LSB +: 8]     = 8'(w_count);
  end

  assign bus.sel     = w_hit_tx || w_hit_st;
  assign bus.rd_data = w_hit_st ? w_status : 32'h0;
  assign tx          = r_tx;

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.iobus_out[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Output register is loaded with the value for the upcoming bit period.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_dout;
          w_baud_nxt  = BAUD_RELOAD;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (r_baud == '0) begin
          w_state_nxt = DATA;
          w_bit_nxt   = 3'd0;
          w_baud_nxt  = BAUD_RELOAD;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt  = r_baud - BW'(1);
        end
      end
      DATA: begin
        if (r_baud == '0) begin
          w_baud_nxt = BAUD_RELOAD;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud - BW'(1);
        end
      end
      STOP: begin
        if (r_baud == '0) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_dout;
            w_baud_nxt  = BAUD_RELOAD;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud - BW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_iobus_uart_tx.sv
// ============================================================================
// tb_iobus_uart_tx : directed self-checking bench for iobus_uart_tx
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_iobus_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] STAT = 32'h1100_0104;

  logic clk;
  logic rst_n;
  logic tx;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic [7:0] rx_q [$];
  int         rx_t [$];
  int         ferr;
  bit         rst_seen;

  iobus_uart_tx_if bif ();

  iobus_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge rst_n) rst_seen = 1'b1;

  // Receiver: samples each bit near its centre on falling clock edges.
  always begin : uart_mon
    logic [7:0] b;
    int         t;
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      t        = cyc;
      rst_seen = 1'b0;
      b        = 8'h00;
      repeat (5) @(negedge clk);
      b[0] = tx;
      for (int i = 1; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = tx;
      end
      repeat (4) @(negedge clk);
      if (!rst_seen) begin
        if (tx !== 1'b1) ferr++;
        rx_q.push_back(b);
        rx_t.push_back(t);
      end
      repeat (2) @(negedge clk);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bif.iobus_addr = a;
    bif.iobus_out  = d;
    bif.iobus_wr   = 1'b1;
    @(posedge clk);
    #1;
    bif.iobus_wr   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
    bif.iobus_wr   = 1'b0;
    bif.iobus_addr = a;
    #1;
    d = bif.rd_data;
    s = bif.sel;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        s;
    bus_read(STAT, d, s);
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx: got %b expected 1", tx);
    end
    n_checks++;
    if (d !== 32'h0000_0004 || s !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_status_in_reset: got %h sel %b expected 00000004 sel 1", d, s);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_read(STAT, d, s);
    n_checks++;
    if (d !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL reset_status_after: got %h expected 00000004", d);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0]  bits;
    logic        exp_tx;
    logic [31:0] d;
    logic        s;
    bits = 8'hA5;
    clear_rx();
    bus_write(BASE, 32'h1234_56A5);
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk);
      #1;
      if (k <= 4)       exp_tx = 1'b0;
      else if (k <= 36) exp_tx = bits[(k - 5) / 4];
      else              exp_tx = 1'b1;
      n_checks++;
      if (tx !== exp_tx) begin
        n_fail++;
        $display("FAIL single_tx k=%0d: got %b expected %b", k, tx, exp_tx);
      end
      if (k == 10 || k == 40 || k == 41) begin
        bus_read(STAT, d, s);
        n_checks++;
        if (d !== ((k == 41) ? 32'h0000_0004 : 32'h0000_0005)) begin
          n_fail++;
          $display("FAIL single_status k=%0d: got %h expected %h", k, d,
                   (k == 41) ? 32'h0000_0004 : 32'h0000_0005);
        end
      end
    end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_rx: got %0d frames first %h expected 1 frame a5",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    clear_rx();
    bus_write(BASE, 32'h55);
    bus_write(BASE, 32'h0F);
    wait_frames(2, 200);
    n_checks++;
    if (rx_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 2", rx_q.size());
    end else begin
      n_checks++;
      if (rx_q[0] !== 8'h55 || rx_q[1] !== 8'h0F) begin
        n_fail++;
        $display("FAIL b2b_data: got %h %h expected 55 0f", rx_q[0], rx_q[1]);
      end
      n_checks++;
      if (rx_t[1] - rx_t[0] != 40) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d expected 40", rx_t[1] - rx_t[0]);
      end
    end
  endtask

  task automatic test_status_decode();
    logic [31:0] addrs [5];
    logic [31:0] exp_d [5];
    logic        exp_s [5];
    logic [31:0] d;
    logic        s;
    addrs = '{32'h1100_0104, 32'h1100_0107, 32'h1100_0100, 32'h1100_0108, 32'h1100_00FC};
    exp_d = '{32'h4, 32'h4, 32'h0, 32'h0, 32'h0};
    exp_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus_read(addrs[i], d, s);
      n_checks++;
      if (d !== exp_d[i] || s !== exp_s[i]) begin
        n_fail++;
        $display("FAIL decode %h: got %h sel %b expected %h sel %b",
                 addrs[i], d, s, exp_d[i], exp_s[i]);
      end
    end
    clear_rx();
    @(posedge clk);
    #1;
    bus_write(32'h1100_0108, 32'hFF);
    bus_write(STAT, 32'hFF);
    bus_read(STAT, d, s);
    n_checks++;
    if (d !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL unmapped_write_status: got %h expected 00000004", d);
    end
    repeat (50) @(posedge clk);
    #1;
    n_checks++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL unmapped_write_frames: got %0d expected 0", rx_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic        s;
    clear_rx();
    for (int i = 0; i < 10; i++) bus_write(BASE, 32'(i));
    bus_read(STAT, d, s);
    n_checks++;
    if (d !== 32'h0000_080B) begin
      n_fail++;
      $display("FAIL ovf_status: got %h expected 0000080b", d);
    end
    @(posedge clk);
    #1;
    bus_read(STAT, d, s);
    n_checks++;
    if (d !== 32'h0000_080B) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %h expected 0000080b", d);
    end
    bus_write(STAT, 32'h8);
    bus_read(STAT, d, s);
    n_checks++;
    if (d !== 32'h0000_0803) begin
      n_fail++;
      $display("FAIL ovf_clear: got %h expected 00000803", d);
    end
    wait_frames(9, 600);
    n_checks++;
    if (rx_q.size() != 9) begin
      n_fail++;
      $display("FAIL ovf_frames: got %0d expected 9", rx_q.size());
    end
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_data[%0d]: got %h expected %h", i, rx_q[i], 8'(i));
      end
    end
    bus_read(STAT, d, s);
    n_checks++;
    if (d !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL ovf_final_status: got %h expected 00000004", d);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]  vals [2];
    logic        bit3 [2];
    logic [31:0] d;
    logic        s;
    int          lows;
    vals = '{8'hFF, 8'h00};
    bit3 = '{1'b1, 1'b0};
    for (int v = 0; v < 2; v++) begin
      clear_rx();
      bus_write(BASE, 32'(vals[v]));
      repeat (18) @(posedge clk);
      #1;
      n_checks++;
      if (tx !== bit3[v]) begin
        n_fail++;
        $display("FAIL rst_pre_bit3 %h: got %b expected %b", vals[v], tx, bit3[v]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (tx !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_async_tx %h: got %b expected 1", vals[v], tx);
      end
      bus_read(STAT, d, s);
      n_checks++;
      if (d !== 32'h0000_0004) begin
        n_fail++;
        $display("FAIL rst_async_status %h: got %h expected 00000004", vals[v], d);
      end
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus_read(STAT, d, s);
      n_checks++;
      if (d !== 32'h0000_0004) begin
        n_fail++;
        $display("FAIL rst_release_status %h: got %h expected 00000004", vals[v], d);
      end
      lows = 0;
      for (int k = 0; k < 60; k++) begin
        @(posedge clk);
        #1;
        if (tx !== 1'b1) lows++;
      end
      n_checks++;
      if (lows != 0 || rx_q.size() != 0) begin
        n_fail++;
        $display("FAIL rst_residual %h: got %0d low cycles %0d frames expected 0 0",
                 vals[v], lows, rx_q.size());
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0]  exp_b [10];
    logic [31:0] d;
    logic        s;
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h77};
    clear_rx();
    for (int i = 0; i < 9; i++) bus_write(BASE, 32'h10 + 32'(i));
    bus_read(STAT, d, s);
    n_checks++;
    if (d !== 32'h0000_0803) begin
      n_fail++;
      $display("FAIL pp_full_status: got %h expected 00000803", d);
    end
    repeat (32) @(posedge clk);
    #1;
    bus_write(BASE, 32'h77);
    bus_read(STAT, d, s);
    n_checks++;
    if (d !== 32'h0000_0803) begin
      n_fail++;
      $display("FAIL pp_same_edge_status: got %h expected 00000803", d);
    end
    wait_frames(10, 800);
    n_checks++;
    if (rx_q.size() != 10) begin
      n_fail++;
      $display("FAIL pp_frames: got %0d expected 10", rx_q.size());
    end
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL pp_data[%0d]: got %h expected %h", i, rx_q[i], exp_b[i]);
      end
    end
    if (rx_q.size() == 10) begin
      n_checks++;
      if (rx_t[9] - rx_t[8] != 40) begin
        n_fail++;
        $display("FAIL pp_last_spacing: got %0d expected 40", rx_t[9] - rx_t[8]);
      end
    end
  endtask

  task automatic test_framing();
    n_checks++;
    if (ferr != 0) begin
      n_fail++;
      $display("FAIL stop_bits: got %0d bad stop bits expected 0", ferr);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    ferr           = 0;
    rst_seen       = 1'b0;
    rst_n          = 1'b0;
    bif.iobus_addr = 32'h0;
    bif.iobus_out  = 32'h0;
    bif.iobus_wr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_status_decode();
    test_overflow();
    test_reset_mid_frame();
    test_push_pop_full();
    test_framing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
